fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the five-stage pipeline. It owns the program counter and issues requests to the instruction cache. It waits out cache misses and applies branch/jump redirects from later stages. It drives the IF pipeline register's hold and flush controls so that IF/ID captures only valid, non-squashed instructions.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Fetch addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues I-cache requests, absorbs
// misses and redirects. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4,
  output logic        if_hold,
  output logic        if_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cycles,
  output logic [31:0] perf_redirects
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;

  assign w_target  = align_pc(redirect_pc);
  assign w_pc_inc  = r_pc + 32'(INST_BYTES);
  assign ic_addr   = r_pc;
  assign pc_out    = r_pc;
  assign pc_plus_4 = w_pc_inc;
  assign inst_out  = ic_rdata;
  assign if_hold   = !inst_valid && !if_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:  w_next_state = FETCH;
      FETCH: begin
        if (!redirect_valid && !ic_valid) w_next_state = MISS;
      end
      MISS: begin
        if (redirect_valid)     w_next_state = DRAIN;
        else if (ic_valid)      w_next_state = FETCH;
      end
      DRAIN: begin
        if (ic_valid) w_next_state = FETCH;
      end
      default: w_next_state = BOOT;
    endcase
  end

  // Redirect beats stall beats deliver; a redirect always bubbles the IF register.
  always_comb begin
    ic_req     = 1'b0;
    inst_valid = 1'b0;
    if_flush   = 1'b0;
    case (r_state)
      FETCH, MISS: begin
        ic_req = 1'b1;
        if (redirect_valid)         if_flush   = 1'b1;
        else if (ic_valid && !stall) inst_valid = 1'b1;
      end
      DRAIN: begin
        ic_req   = 1'b1;
        if_flush = redirect_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= 32'h0000_0000;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid)  r_pc <= w_target;
          else if (inst_valid) r_pc <= w_pc_inc;
        end
        MISS: begin
          if (redirect_valid)  r_pend_pc <= w_target;
          else if (inst_valid) r_pc <= w_pc_inc;
        end
        DRAIN: begin
          // The miss in flight must complete before the new target is requested.
          if (ic_valid)            r_pc      <= redirect_valid ? w_target : r_pend_pc;
          else if (redirect_valid) r_pend_pc <= w_target;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched     <= 32'h0;
      perf_miss_cycles <= 32'h0;
      perf_redirects   <= 32'h0;
    end else begin
      if (inst_valid)                        perf_fetched     <= perf_fetched + 32'd1;
      if (r_state == MISS || r_state == DRAIN) perf_miss_cycles <= perf_miss_cycles + 32'd1;
      if (redirect_valid && r_state != BOOT) perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4;
  logic        if_hold;
  logic        if_flush;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_miss_cycles;
  logic [31:0] perf_redirects;
`endif

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_valid       (ic_valid),
    .ic_rdata       (ic_rdata),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .pc_plus_4      (pc_plus_4),
    .if_hold        (if_hold),
    .if_flush       (if_flush)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_miss_cycles (perf_miss_cycles),
    .perf_redirects   (perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: a booting flag, an outstanding-miss flag and a "drop the miss" flag.
  bit          m_boot;
  bit          m_wait;
  bit          m_squash;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_fetched;
  logic [31:0] m_misscyc;
  logic [31:0] m_redirs;

  logic [31:0] obs_addr;
  logic        obs_iv;
  logic        obs_fl;
  logic [31:0] obs_p4;

  task automatic model_reset();
    m_boot = 1; m_wait = 0; m_squash = 0;
    m_pc = RST_PC; m_pend = 32'h0;
    m_fetched = 0; m_misscyc = 0; m_redirs = 0;
  endtask

  // Called at a falling edge: drive one cycle, check outputs, advance the model.
  task automatic step(input bit s, input bit rv, input logic [31:0] rpc,
                      input bit v, input logic [31:0] d);
    bit          e_iv;
    bit          e_fl;
    logic [31:0] tgt;
    stall = s; redirect_valid = rv; redirect_pc = rpc; ic_valid = v; ic_rdata = d;
    #1;
    e_iv = 0; e_fl = 0;
    tgt  = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_miss", perf_miss_cycles, m_misscyc);
    check("perf_redir", perf_redirects, m_redirs);
`endif
    if (!m_boot) begin
      if (m_wait) m_misscyc++;
      if (rv) begin
        e_fl = 1; m_redirs++;
        if (m_squash) begin
          if (v) begin m_pc = tgt; m_wait = 0; m_squash = 0; end
          else m_pend = tgt;
        end else if (m_wait) begin
          m_pend = tgt; m_squash = 1;
        end else m_pc = tgt;
      end else if (m_squash) begin
        if (v) begin m_pc = m_pend; m_wait = 0; m_squash = 0; end
      end else if (v) begin
        m_wait = 0;
        if (!s) begin e_iv = 1; m_fetched++; end
      end else m_wait = 1;
    end
    check("ic_req", 32'(ic_req), 32'(!m_boot));
    check("ic_addr", ic_addr, obs_pc_prev());
    check("pc_plus_4", pc_plus_4, obs_pc_prev() + 32'd4);
    check("inst_valid", 32'(inst_valid), 32'(e_iv));
    check("if_flush", 32'(if_flush), 32'(e_fl));
    check("if_hold", 32'(if_hold), 32'(!e_iv && !e_fl));
    if (e_iv) check("inst_out", inst_out, d);
    obs_addr = ic_addr; obs_iv = inst_valid; obs_fl = if_flush; obs_p4 = pc_plus_4;
    if (e_iv) m_pc = m_pc + 32'd4;
    m_boot = 0;
    @(negedge clk);
  endtask

  // PC the model held at the start of the current cycle (advanced only on delivery,
  // which is applied after the checks, or on redirect/drain completion below).
  logic [31:0] pc_snap;
  function automatic logic [31:0] obs_pc_prev();
    return pc_snap;
  endfunction

  task automatic stepc(input bit s, input bit rv, input logic [31:0] rpc,
                       input bit v, input logic [31:0] d);
    pc_snap = m_pc;
    check("pc_out", pc_out, m_pc);
    step(s, rv, rpc, v, d);
  endtask

  initial begin
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; ic_valid = 0; ic_rdata = 0;
    model_reset();
    #12;
    check("rst_ic_req", 32'(ic_req), 32'h0);
    check("rst_pc", pc_out, RST_PC);
    check("rst_iv", 32'(inst_valid), 32'h0);
    check("rst_flush", 32'(if_flush), 32'h0);
    check("rst_hold", 32'(if_hold), 32'h1);
    @(negedge clk);
    rst = 0;

    stepc(0, 0, 0, 0, 0);
    check("boot_noreq", obs_addr, RST_PC);
    stepc(0, 0, 0, 1, 32'hA000_0001); check("hit_addr0", obs_addr, 32'h100);
    stepc(0, 0, 0, 1, 32'hA000_0002); check("hit_addr1", obs_addr, 32'h104);
    stepc(0, 0, 0, 1, 32'hA000_0003); check("hit_addr2", obs_addr, 32'h108);
    // 3-cycle miss at 0x10C
    for (int i = 0; i < 3; i++) stepc(0, 0, 0, 0, 0);
    stepc(0, 0, 0, 1, 32'hB000_0000);
    check("miss_deliver", 32'(obs_iv), 32'h1);
    check("miss_p4", obs_p4, 32'h110);
    // Stall held two cycles on a hit at 0x110
    stepc(1, 0, 0, 1, 32'hC0); check("stall_addr0", obs_addr, 32'h110);
    stepc(1, 0, 0, 1, 32'hC0); check("stall_iv", 32'(obs_iv), 32'h0);
    stepc(0, 0, 0, 1, 32'hC1); check("stall_rel", 32'(obs_iv), 32'h1);
    // Redirect on the 2nd cycle of a 4-cycle miss at 0x114
    stepc(0, 0, 0, 0, 0);
    stepc(0, 1, 32'h200, 0, 0); check("mred_flush", 32'(obs_fl), 32'h1);
    stepc(0, 0, 0, 0, 0);
    stepc(0, 0, 0, 1, 32'hDEAD); check("mred_drop", 32'(obs_iv), 32'h0);
    stepc(0, 0, 0, 1, 32'h1); check("mred_target", obs_addr, 32'h200);
    // Redirect and stall together in FETCH
    stepc(1, 1, 32'h303, 1, 32'h2); check("rs_flush", 32'(obs_fl), 32'h1);
    stepc(0, 0, 0, 1, 32'h3); check("rs_target", obs_addr, 32'h300);
    // Wrap past the top of the address space
    stepc(0, 1, 32'hFFFF_FFFF, 0, 0);
    stepc(0, 0, 0, 1, 32'h4); check("wrap_top", obs_addr, 32'hFFFF_FFFC);
    stepc(0, 0, 0, 1, 32'h5); check("wrap_zero", obs_addr, 32'h0);
    // Reset in the middle of a miss
    stepc(0, 0, 0, 0, 0);
    stepc(0, 0, 0, 0, 0);
    rst = 1;
    #1;
    check("mrst_req", 32'(ic_req), 32'h0);
    check("mrst_pc", pc_out, RST_PC);
    model_reset();
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      bit s, rv, v;
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0) && !m_boot;
      v  = ($urandom_range(0, 9) < 6) && !m_boot;
      stepc(s, rv, $urandom(), v, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
